// File: rtl/display_pkg.sv
// Shared definitions for the display sharing logic.
//   BLANK_CODE : digit code the seven-segment decoder renders as all-off
//   BCD_W      : width of one requester's {d4,d3,d2,d1} word
//   DIGIT_W    : width of one display digit code
//   arb_state_e: ownership FSM encoding (ST_IDLE / ST_OWN)
//   lz_blank() : leading-zero blanking of a 4-digit word
package display_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam int         BCD_W      = 16;
  localparam int         DIGIT_W    = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  // Scan d4, d3, d2 from the top; a digit is blanked while it and every
  // digit above it are zero. d1 always shows, so a value of 0 reads "0".
  // Codes above 9 are non-zero and therefore stop the blanking.
  function automatic logic [BCD_W-1:0] lz_blank(input logic [BCD_W-1:0] w);
    logic [BCD_W-1:0] r;
    logic             lead;
    r    = w;
    lead = 1'b1;
    for (int k = 3; k >= 1; k--) begin
      if (lead && (w[k*DIGIT_W +: DIGIT_W] == 4'h0)) begin
        r[k*DIGIT_W +: DIGIT_W] = BLANK_CODE;
      end else begin
        lead = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_next_picker.sv
// Combinational round-robin search.
//   req_i   : request vector to search
//   start_i : index to search after (search starts at start_i+1, wraps)
//   found_o : at least one bit of req_i is set
//   idx_o   : first set index after start_i, 0 when nothing is found
module rr_next_picker #(
  parameter int N_REQ = 3,
  parameter int IDX_W = 3
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] start_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  int pos;

  // Walk from the farthest candidate towards the nearest one; the last hit
  // written is the closest set bit after start_i.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    pos     = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      pos = (int'(start_i) + k) % N_REQ;
      if (req_i[pos]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/display_share_arbiter.sv
// Shares one 4-digit seven-segment display among N_REQ requesters.
// Round-robin ownership with a minimum time slice measured in tick strobes,
// leading-zero blanking and per-requester blink of the owner's digits.
//   clk, rst          : clock, asynchronous active-high reset
//   tick              : one-clk timing strobe; hold and blink timers only
//                       advance on it
//   req, blink        : per-requester request level / blink wish
//   bcd_in            : requester i word at [16i+15:16i] = {d4,d3,d2,d1}
//   grant, owner_id   : one-hot owner and its index (0 when idle)
//   busy              : display currently owned
//   digit4..digit1    : registered digit codes for the display scanner
//   dbg_state         : FSM state (ST_IDLE / ST_OWN)
module display_share_arbiter
  import display_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int HOLD_TICKS  = 400,
  parameter int BLINK_TICKS = 200,
  parameter int LZ_BLANK    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       blink,
  input  logic [BCD_W*N_REQ-1:0] bcd_in,
  output logic [N_REQ-1:0]       grant,
  output logic [2:0]             owner_id,
  output logic                   busy,
  output logic [DIGIT_W-1:0]     digit4,
  output logic [DIGIT_W-1:0]     digit3,
  output logic [DIGIT_W-1:0]     digit2,
  output logic [DIGIT_W-1:0]     digit1,
  output logic                   dbg_state
);

  localparam int IDX_W = 3;
  localparam int HW    = $clog2(HOLD_TICKS + 1);
  localparam int BW    = $clog2(BLINK_TICKS + 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;
  logic [BCD_W-1:0]  digits_q, digits_d;

  logic [N_REQ-1:0]  grant_vec;
  logic              owner_req;
  logic              owner_blink;
  logic [BCD_W-1:0]  owner_word;
  logic              arb_found, hand_found;
  logic [IDX_W-1:0]  arb_idx, hand_idx;
  logic              take;
  logic [IDX_W-1:0]  take_idx;

  assign grant_vec   = (state_q == ST_OWN) ? (N_REQ'(1) << owner_q) : '0;
  assign owner_req   = |(req & grant_vec);
  assign owner_blink = |(blink & grant_vec);

  // Fresh arbitration from idle, resuming after the last owner.
  rr_next_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb_pick (
    .req_i   (req),
    .start_i (rr_ptr_q),
    .found_o (arb_found),
    .idx_o   (arb_idx)
  );

  // Handover search among everyone except the current owner; serves both
  // the owner-drop and the slice-expiry cases.
  rr_next_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_hand_pick (
    .req_i   (req & ~grant_vec),
    .start_i (owner_q),
    .found_o (hand_found),
    .idx_o   (hand_idx)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    hold_cnt_d  = hold_cnt_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    take        = 1'b0;
    take_idx    = '0;
    case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          take     = 1'b1;
          take_idx = arb_idx;
        end
      end
      default: begin
        // Owner drop wins over a simultaneous tick or slice expiry.
        if (!owner_req) begin
          if (hand_found) begin
            take     = 1'b1;
            take_idx = hand_idx;
          end else begin
            state_d     = ST_IDLE;
            hold_cnt_d  = '0;
            blink_cnt_d = '0;
            phase_d     = 1'b0;
          end
        end else if ((hold_cnt_q == HW'(HOLD_TICKS)) && hand_found) begin
          take     = 1'b1;
          take_idx = hand_idx;
        end else if (tick) begin
          if (hold_cnt_q != HW'(HOLD_TICKS)) hold_cnt_d = hold_cnt_q + 1'b1;
          if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
        end
      end
    endcase
    // Any grant change restarts the slice and the blink cadence.
    if (take) begin
      state_d     = ST_OWN;
      owner_d     = take_idx;
      rr_ptr_d    = take_idx;
      hold_cnt_d  = '0;
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end
  end

  // Digits follow the registered owner, so they trail a grant change by one
  // clock; blink blanking is applied on top of leading-zero blanking.
  always_comb begin
    owner_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_vec[i]) owner_word = bcd_in[i*BCD_W +: BCD_W];
    end
    if (state_q == ST_IDLE) begin
      digits_d = {4{BLANK_CODE}};
    end else begin
      digits_d = (LZ_BLANK != 0) ? lz_blank(owner_word) : owner_word;
      if (owner_blink && phase_q) digits_d = {4{BLANK_CODE}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= IDX_W'(N_REQ - 1);
      hold_cnt_q  <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      digits_q    <= {4{BLANK_CODE}};
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      digits_q    <= digits_d;
    end
  end

  assign grant     = grant_vec;
  assign owner_id  = (state_q == ST_OWN) ? owner_q : 3'd0;
  assign busy      = |grant_vec;
  assign digit4    = digits_q[15:12];
  assign digit3    = digits_q[11:8];
  assign digit2    = digits_q[7:4];
  assign digit1    = digits_q[3:0];
  assign dbg_state = state_q;

endmodule
